hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 45 ++++
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Brief    : Signal bundle between the pipeline stages and the hazard
//            controller (decode/execute/memory status in, stall/flush out).
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
  logic [4:0]  i_ID_Rs1;
  logic [4:0]  i_ID_Rs2;
  logic        i_ID_UsesRs1;
  logic        i_ID_UsesRs2;
  logic [4:0]  i_EX_RegDst;
  logic        i_EX_MemToReg;
  logic        i_EX_RegWrEn;
  logic        i_EX_Redirect;
  logic        i_MEM_Req;
  logic        i_MEM_Ready;
  logic        o_IF_Stall;
  logic        o_ID_Stall;
  logic        o_Flush_IFID;
  logic        o_Flush_IDEX;
  logic [1:0]  o_State;
  logic [31:0] o_StallCycles;
  logic [31:0] o_FlushCount;

  // Pipeline side: reports stage status, consumes stall/flush controls.
  modport master (
    output i_ID_Rs1, i_ID_Rs2, i_ID_UsesRs1, i_ID_UsesRs2,
    output i_EX_RegDst, i_EX_MemToReg, i_EX_RegWrEn, i_EX_Redirect,
    output i_MEM_Req, i_MEM_Ready,
    input  o_IF_Stall, o_ID_Stall, o_Flush_IFID, o_Flush_IDEX,
    input  o_State, o_StallCycles, o_FlushCount
  );

  // Hazard controller side.
  modport slave (
    input  i_ID_Rs1, i_ID_Rs2, i_ID_UsesRs1, i_ID_UsesRs2,
    input  i_EX_RegDst, i_EX_MemToReg, i_EX_RegWrEn, i_EX_Redirect,
    input  i_MEM_Req, i_MEM_Ready,
    output o_IF_Stall, o_ID_Stall, o_Flush_IFID, o_Flush_IDEX,
    output o_State, o_StallCycles, o_FlushCount
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard controller: load-use bubbles, data-memory wait
//            stalls and branch/jump redirect flushes (RUN/MEM_WAIT/FLUSH).
//            Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
  input  wire logic    clk,
  input  wire logic    reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_pend;    // redirect deferred by a memory wait
  logic   r_replay;  // current FLUSH cycle replays that deferred redirect

  logic   w_mem_wait;
  logic   w_rs1_hit;
  logic   w_rs2_hit;
  logic   w_load_use;
  logic   w_if_stall;
  logic   w_id_stall;
  logic   w_flush_ifid;
  logic   w_flush_idex;
  logic   w_set_pend;
  logic   w_enter_replay;

  assign w_mem_wait = hz.i_MEM_Req & ~hz.i_MEM_Ready;
  assign w_rs1_hit  = hz.i_ID_UsesRs1 & (hz.i_ID_Rs1 == hz.i_EX_RegDst);
  assign w_rs2_hit  = hz.i_ID_UsesRs2 & (hz.i_ID_Rs2 == hz.i_EX_RegDst);
  assign w_load_use = hz.i_EX_MemToReg & hz.i_EX_RegWrEn &
                      (hz.i_EX_RegDst != 5'd0) & (w_rs1_hit | w_rs2_hit);

  always_comb begin
    w_next_state   = r_state;
    w_if_stall     = 1'b0;
    w_id_stall     = 1'b0;
    w_flush_ifid   = 1'b0;
    w_flush_idex   = 1'b0;
    w_set_pend     = 1'b0;
    w_enter_replay = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_wait) begin
          w_if_stall   = 1'b1;
          w_id_stall   = 1'b1;
          w_set_pend   = hz.i_EX_Redirect;
          w_next_state = ST_MEM_WAIT;
        end else if (hz.i_EX_Redirect) begin
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
          w_next_state = ST_FLUSH;
        end else if (w_load_use) begin
          w_if_stall   = 1'b1;
          w_id_stall   = 1'b1;
          w_flush_idex = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!hz.i_MEM_Ready) begin
          w_if_stall = 1'b1;
          w_id_stall = 1'b1;
          w_set_pend = hz.i_EX_Redirect;
        end else if (r_pend || hz.i_EX_Redirect) begin
          w_next_state   = ST_FLUSH;
          w_enter_replay = 1'b1;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // A replayed or fresh redirect kills ID/EX and costs one more cycle.
        w_flush_ifid = 1'b1;
        w_flush_idex = r_replay | hz.i_EX_Redirect;
        w_next_state = (r_replay || hz.i_EX_Redirect) ? ST_FLUSH : ST_RUN;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_RUN;
      r_pend   <= 1'b0;
      r_replay <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_replay <= w_enter_replay;
      if (w_next_state == ST_FLUSH) begin
        r_pend <= 1'b0;
      end else if (w_set_pend) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Controls are forced low for the whole time reset is held.
  assign hz.o_IF_Stall   = reset & w_if_stall;
  assign hz.o_ID_Stall   = reset & w_id_stall;
  assign hz.o_Flush_IFID = reset & w_flush_ifid;
  assign hz.o_Flush_IDEX = reset & w_flush_idex;
  assign hz.o_State      = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if (w_if_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_flush_idex && (r_flush_count != 32'hFFFF_FFFF)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign hz.o_StallCycles = r_stall_cycles;
  assign hz.o_FlushCount  = r_flush_count;
`else
  assign hz.o_StallCycles = 32'd0;
  assign hz.o_FlushCount  = 32'd0;
`endif

endmodule
`default_nettype wire
